// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and helpers for the branch prediction tracker.
//                Holds the default table index width, the PC-to-word helper
//                used to index the direction table, the in-flight FIFO entry
//                layout and the update FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int IDX_W_DEF = 10;

    // Instruction-word address of a PC. Callers cast the result down to
    // their table index width, which yields PC[IDX_W+1:2].
    function automatic logic [31:0] pc_word_idx(input logic [31:0] pc);
        return {2'b00, pc[31:2]};
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } fifo_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } upd_state_t;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_inflight_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bp_inflight_fifo
//  Description : DEPTH-entry synchronous FIFO of predicted branches awaiting
//                resolution. Head is presented combinationally. Clear has
//                priority over push/pop and empties the FIFO in one edge.
//  Ports       : i_clk, i_rst_n (sync, active-low), i_push, i_pop, i_clear,
//                i_wr_data (entry to append), o_full, o_empty, o_head.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_clear,
    input  fifo_entry_t i_wr_data,
    output logic        o_full,
    output logic        o_empty,
    output fifo_entry_t o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fifo_entry_t      r_mem_q [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [CNT_W-1:0] r_count_q,  w_count_d;

    assign o_full  = (r_count_q == CNT_W'(DEPTH));
    assign o_empty = (r_count_q == '0);
    assign o_head  = r_mem_q[r_rd_ptr_q];

    // DEPTH is a power of two, so pointer increment wraps naturally.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_clear) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (i_push) w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
            if (i_pop)  w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   w_count_d = r_count_q + CNT_W'(1);
                2'b01:   w_count_d = r_count_q - CNT_W'(1);
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // When full with a simultaneous pop, the write lands in the slot being
    // popped; the head has already been consumed this cycle.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_mem_q[r_wr_ptr_q] <= i_wr_data;
        end
    end

endmodule : bp_inflight_fifo
`default_nettype wire

// File: rtl/branch_pred_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pred_tracker
//  Description : Companion to the 2-bit direction table. Latches the table's
//                prediction for each fetched branch, keeps in-flight branches
//                in order, compares each resolution with its prediction and
//                drives the table update strobe.
//  Ports       : CLK, RESET (sync, active-low)
//                Fetch   : FetchValid, FetchIsBranch, FetchPC, PredVec,
//                          FetchStall
//                Predict : PredValid, PredTaken, PredPC (registered)
//                Resolve : ResolveValid, ResolveReady, ResolveTaken, ResolvePC
//                Update  : UpdBranch, UpdTaken, UpdPC
//                Status  : Mispredict, FlushReq (pulses), OrderErr (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_tracker
    import bp_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FetchValid,
    input  logic                FetchIsBranch,
    input  logic [31:0]         FetchPC,
    input  logic [2**IDX_W-1:0] PredVec,
    output logic                FetchStall,
    output logic                PredValid,
    output logic                PredTaken,
    output logic [31:0]         PredPC,
    input  logic                ResolveValid,
    output logic                ResolveReady,
    input  logic                ResolveTaken,
    input  logic [31:0]         ResolvePC,
    output logic                UpdBranch,
    output logic                UpdTaken,
    output logic [31:0]         UpdPC,
    output logic                Mispredict,
    output logic                FlushReq,
    output logic                OrderErr
);

    upd_state_t  r_state_q,      w_state_d;
    logic        r_pred_valid_q, w_pred_valid_d;
    logic        r_pred_taken_q, w_pred_taken_d;
    logic [31:0] r_pred_pc_q,    w_pred_pc_d;
    logic        r_upd_taken_q,  w_upd_taken_d;
    logic [31:0] r_upd_pc_q,     w_upd_pc_d;
    logic        r_mispred_q,    w_mispred_d;
    logic        r_order_err_q,  w_order_err_d;

    logic [IDX_W-1:0] w_fetch_idx;
    fifo_entry_t      w_wr_entry;
    fifo_entry_t      w_head;
    logic             w_full, w_empty;
    logic             w_accept, w_pop, w_mispredict, w_order_bad, w_push;

    assign w_fetch_idx = IDX_W'(pc_word_idx(FetchPC));

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.pc   = FetchPC;
        w_wr_entry.pred = PredVec[w_fetch_idx];
    end

    // Ready is gated by RESET so nothing is accepted while reset is held.
    assign ResolveReady = RESET & (r_state_q == IDLE);
    assign w_accept     = ResolveValid & ResolveReady;
    assign w_pop        = w_accept & ~w_empty;
    // Only a real head entry can mispredict; an empty resolve never flushes.
    assign w_mispredict = w_pop & (w_head.pred != ResolveTaken);
    assign w_order_bad  = w_accept & (w_empty | (w_head.pc != ResolvePC));
    // A full FIFO still takes a push when the head leaves the same cycle;
    // a flush drops any push that coincides with it.
    assign w_push       = FetchValid & FetchIsBranch & (~w_full | w_pop)
                          & ~w_mispredict;

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (CLK),
        .i_rst_n   (RESET),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_clear   (w_mispredict),
        .i_wr_data (w_wr_entry),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_head)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_pred_valid_d = w_push;
        w_pred_taken_d = r_pred_taken_q;
        w_pred_pc_d    = r_pred_pc_q;
        w_upd_taken_d  = r_upd_taken_q;
        w_upd_pc_d     = r_upd_pc_q;
        w_mispred_d    = w_mispredict;
        w_order_err_d  = r_order_err_q | w_order_bad;

        if (w_push) begin
            w_pred_taken_d = w_wr_entry.pred;
            w_pred_pc_d    = FetchPC;
        end

        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    w_state_d     = PULSE;
                    w_upd_taken_d = ResolveTaken;
                    w_upd_pc_d    = ResolvePC;
                end
            end
            PULSE:   w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state_q      <= IDLE;
            r_pred_valid_q <= 1'b0;
            r_pred_taken_q <= 1'b0;
            r_pred_pc_q    <= '0;
            r_upd_taken_q  <= 1'b0;
            r_upd_pc_q     <= '0;
            r_mispred_q    <= 1'b0;
            r_order_err_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_pred_valid_q <= w_pred_valid_d;
            r_pred_taken_q <= w_pred_taken_d;
            r_pred_pc_q    <= w_pred_pc_d;
            r_upd_taken_q  <= w_upd_taken_d;
            r_upd_pc_q     <= w_upd_pc_d;
            r_mispred_q    <= w_mispred_d;
            r_order_err_q  <= w_order_err_d;
        end
    end

    assign FetchStall = w_full;
    assign PredValid  = r_pred_valid_q;
    assign PredTaken  = r_pred_taken_q;
    assign PredPC     = r_pred_pc_q;
    assign UpdBranch  = (r_state_q == PULSE);
    assign UpdTaken   = r_upd_taken_q;
    assign UpdPC      = r_upd_pc_q;
    assign Mispredict = r_mispred_q;
    assign FlushReq   = r_mispred_q;
    assign OrderErr   = r_order_err_q;

endmodule : branch_pred_tracker
`default_nettype wire

// File: tb/tb_branch_pred_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_pred_tracker
//  Description : Directed self-checking bench for branch_pred_tracker.
//                Inputs change 1 ns after a rising edge; outputs are sampled
//                at that point, never on the edge itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pred_tracker;

    localparam int IDX_W = 10;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              FetchValid, FetchIsBranch;
    logic [31:0]       FetchPC;
    logic [1023:0]     PredVec;
    logic              FetchStall, PredValid, PredTaken;
    logic [31:0]       PredPC;
    logic              ResolveValid, ResolveReady, ResolveTaken;
    logic [31:0]       ResolvePC;
    logic              UpdBranch, UpdTaken;
    logic [31:0]       UpdPC;
    logic              Mispredict, FlushReq, OrderErr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    branch_pred_tracker #(.IDX_W(IDX_W), .DEPTH(4)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .FetchValid    (FetchValid),
        .FetchIsBranch (FetchIsBranch),
        .FetchPC       (FetchPC),
        .PredVec       (PredVec),
        .FetchStall    (FetchStall),
        .PredValid     (PredValid),
        .PredTaken     (PredTaken),
        .PredPC        (PredPC),
        .ResolveValid  (ResolveValid),
        .ResolveReady  (ResolveReady),
        .ResolveTaken  (ResolveTaken),
        .ResolvePC     (ResolvePC),
        .UpdBranch     (UpdBranch),
        .UpdTaken      (UpdTaken),
        .UpdPC         (UpdPC),
        .Mispredict    (Mispredict),
        .FlushReq      (FlushReq),
        .OrderErr      (OrderErr)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        FetchValid = 1'b1; FetchIsBranch = 1'b1; FetchPC = pc;
        step();
        FetchValid = 1'b0; FetchIsBranch = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; FetchValid = 1'b1; FetchIsBranch = 1'b1; FetchPC = 32'h100;
        step(); step();
        n_checks++; if (PredValid !== 1'b0) begin n_fail++; $display("FAIL rst_pred_valid: got %b want 0", PredValid); end
        n_checks++; if (UpdBranch !== 1'b0) begin n_fail++; $display("FAIL rst_upd_branch: got %b want 0", UpdBranch); end
        n_checks++; if ({Mispredict, FlushReq, OrderErr} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b want 000", {Mispredict, FlushReq, OrderErr}); end
        n_checks++; if (ResolveReady !== 1'b0) begin n_fail++; $display("FAIL rst_ready_in_reset: got %b want 0", ResolveReady); end
        n_checks++; if (FetchStall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", FetchStall); end
        FetchValid = 1'b0; FetchIsBranch = 1'b0;
        RESET = 1'b1;
        #1;
        n_checks++; if (ResolveReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", ResolveReady); end
    endtask

    task automatic test_lookup();
        PredVec[5] = 1'b1; PredVec[6] = 1'b0;
        push(32'h14);
        n_checks++; if (PredValid !== 1'b1) begin n_fail++; $display("FAIL lookup0_valid: got %b want 1", PredValid); end
        n_checks++; if (PredTaken !== 1'b1) begin n_fail++; $display("FAIL lookup0_taken: got %b want 1", PredTaken); end
        n_checks++; if (PredPC !== 32'h14) begin n_fail++; $display("FAIL lookup0_pc: got %h want 00000014", PredPC); end
        push(32'h18);
        n_checks++; if (PredTaken !== 1'b0) begin n_fail++; $display("FAIL lookup1_taken: got %b want 0", PredTaken); end
        n_checks++; if (PredPC !== 32'h18) begin n_fail++; $display("FAIL lookup1_pc: got %h want 00000018", PredPC); end
        step();
        n_checks++; if (PredValid !== 1'b0) begin n_fail++; $display("FAIL lookup_idle_valid: got %b want 0", PredValid); end
    endtask

    task automatic test_correct_resolve();
        ResolveValid = 1'b1; ResolveTaken = 1'b1; ResolvePC = 32'h14;
        step();
        ResolveValid = 1'b0;
        n_checks++; if (UpdBranch !== 1'b1) begin n_fail++; $display("FAIL corr_upd_branch: got %b want 1", UpdBranch); end
        n_checks++; if (UpdTaken !== 1'b1) begin n_fail++; $display("FAIL corr_upd_taken: got %b want 1", UpdTaken); end
        n_checks++; if (UpdPC !== 32'h14) begin n_fail++; $display("FAIL corr_upd_pc: got %h want 00000014", UpdPC); end
        n_checks++; if (Mispredict !== 1'b0) begin n_fail++; $display("FAIL corr_mispredict: got %b want 0", Mispredict); end
        n_checks++; if (ResolveReady !== 1'b0) begin n_fail++; $display("FAIL corr_ready_pulse: got %b want 0", ResolveReady); end
        step();
        n_checks++; if (UpdBranch !== 1'b0) begin n_fail++; $display("FAIL corr_upd_low: got %b want 0", UpdBranch); end
        n_checks++; if (ResolveReady !== 1'b1) begin n_fail++; $display("FAIL corr_ready_back: got %b want 1", ResolveReady); end
        // Head is now {0x18, not-taken}; resolve matches.
        ResolveValid = 1'b1; ResolveTaken = 1'b0; ResolvePC = 32'h18;
        step();
        ResolveValid = 1'b0;
        n_checks++; if ({UpdBranch, UpdTaken, Mispredict, OrderErr} !== 4'b1000) begin n_fail++; $display("FAIL corr2_upd: got %b want 1000", {UpdBranch, UpdTaken, Mispredict, OrderErr}); end
        step();
    endtask

    task automatic test_mispredict_flush();
        PredVec[8] = 1'b1; PredVec[9] = 1'b0; PredVec[10] = 1'b1;
        push(32'h20); push(32'h24); push(32'h28);
        FetchValid = 1'b1; FetchIsBranch = 1'b1; FetchPC = 32'h2C;
        ResolveValid = 1'b1; ResolveTaken = 1'b0; ResolvePC = 32'h20;
        step();
        FetchValid = 1'b0; FetchIsBranch = 1'b0; ResolveValid = 1'b0;
        n_checks++; if ({Mispredict, FlushReq} !== 2'b11) begin n_fail++; $display("FAIL flush_pulse: got %b want 11", {Mispredict, FlushReq}); end
        n_checks++; if (PredValid !== 1'b0) begin n_fail++; $display("FAIL flush_push_dropped: got %b want 0", PredValid); end
        n_checks++; if ({UpdBranch, UpdTaken} !== 2'b10) begin n_fail++; $display("FAIL flush_upd: got %b want 10", {UpdBranch, UpdTaken}); end
        n_checks++; if (UpdPC !== 32'h20) begin n_fail++; $display("FAIL flush_upd_pc: got %h want 00000020", UpdPC); end
        n_checks++; if (OrderErr !== 1'b0) begin n_fail++; $display("FAIL flush_order: got %b want 0", OrderErr); end
        step();
        n_checks++; if ({Mispredict, FlushReq} !== 2'b00) begin n_fail++; $display("FAIL flush_one_cycle: got %b want 00", {Mispredict, FlushReq}); end
        // An emptied FIFO takes exactly four pushes before stalling.
        PredVec[12] = 1'b1; PredVec[13] = 1'b0; PredVec[14] = 1'b1; PredVec[15] = 1'b1;
        push(32'h30); push(32'h34); push(32'h38);
        n_checks++; if (FetchStall !== 1'b0) begin n_fail++; $display("FAIL flush_count3_stall: got %b want 0", FetchStall); end
        push(32'h3C);
        n_checks++; if (FetchStall !== 1'b1) begin n_fail++; $display("FAIL flush_count4_stall: got %b want 1", FetchStall); end
    endtask

    task automatic test_full_simultaneous();
        logic [31:0] pcs [4];
        logic        tkn [4];
        pcs = '{32'h34, 32'h38, 32'h3C, 32'h40};
        tkn = '{1'b0, 1'b1, 1'b1, 1'b0};
        PredVec[16] = 1'b0;
        FetchValid = 1'b1; FetchIsBranch = 1'b1; FetchPC = 32'h40;
        ResolveValid = 1'b1; ResolveTaken = 1'b1; ResolvePC = 32'h30;
        step();
        FetchValid = 1'b0; FetchIsBranch = 1'b0; ResolveValid = 1'b0;
        n_checks++; if ({PredValid, PredTaken} !== 2'b10) begin n_fail++; $display("FAIL full_push_taken: got %b want 10", {PredValid, PredTaken}); end
        n_checks++; if (PredPC !== 32'h40) begin n_fail++; $display("FAIL full_push_pc: got %h want 00000040", PredPC); end
        n_checks++; if ({UpdBranch, Mispredict} !== 2'b10) begin n_fail++; $display("FAIL full_resolve: got %b want 10", {UpdBranch, Mispredict}); end
        n_checks++; if (FetchStall !== 1'b1) begin n_fail++; $display("FAIL full_still_full: got %b want 1", FetchStall); end
        step();
        // Push without a pop while full must be refused.
        push(32'h44);
        n_checks++; if (PredValid !== 1'b0) begin n_fail++; $display("FAIL full_stall_refused: got %b want 0", PredValid); end
        for (int i = 0; i < 4; i++) begin
            ResolveValid = 1'b1; ResolveTaken = tkn[i]; ResolvePC = pcs[i];
            step();
            ResolveValid = 1'b0;
            n_checks++;
            if ({UpdBranch, Mispredict, OrderErr} !== 3'b100 || UpdPC !== pcs[i]) begin
                n_fail++;
                $display("FAIL full_order_%0d: got upd/misp/oerr=%b pc=%h want 100 pc=%h", i, {UpdBranch, Mispredict, OrderErr}, UpdPC, pcs[i]);
            end
            step();
        end
        n_checks++; if (FetchStall !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", FetchStall); end
    endtask

    task automatic test_errors();
        ResolveValid = 1'b1; ResolveTaken = 1'b1; ResolvePC = 32'h50;
        step();
        ResolveValid = 1'b0;
        n_checks++; if ({UpdBranch, Mispredict, OrderErr} !== 3'b101) begin n_fail++; $display("FAIL empty_resolve: got %b want 101", {UpdBranch, Mispredict, OrderErr}); end
        n_checks++; if (UpdPC !== 32'h50) begin n_fail++; $display("FAIL empty_upd_pc: got %h want 00000050", UpdPC); end
        step(); step(); step();
        n_checks++; if (OrderErr !== 1'b1) begin n_fail++; $display("FAIL order_sticky: got %b want 1", OrderErr); end
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        n_checks++; if (OrderErr !== 1'b0) begin n_fail++; $display("FAIL order_reset_clear: got %b want 0", OrderErr); end
        PredVec[17] = 1'b1;
        push(32'h44);
        // Wrong PC and opposite direction: update uses the resolve values,
        // mispredict is still judged against the head's prediction.
        ResolveValid = 1'b1; ResolveTaken = 1'b0; ResolvePC = 32'h40;
        step();
        ResolveValid = 1'b0;
        n_checks++; if ({UpdBranch, UpdTaken, OrderErr} !== 3'b101) begin n_fail++; $display("FAIL pc_mismatch_upd: got %b want 101", {UpdBranch, UpdTaken, OrderErr}); end
        n_checks++; if (UpdPC !== 32'h40) begin n_fail++; $display("FAIL pc_mismatch_upd_pc: got %h want 00000040", UpdPC); end
        n_checks++; if (Mispredict !== 1'b1) begin n_fail++; $display("FAIL pc_mismatch_misp: got %b want 1", Mispredict); end
        step();
    endtask

    initial begin
        RESET = 1'b0; FetchValid = 1'b0; FetchIsBranch = 1'b0; FetchPC = '0;
        PredVec = '0; ResolveValid = 1'b0; ResolveTaken = 1'b0; ResolvePC = '0;
        test_reset();
        test_lookup();
        test_correct_resolve();
        test_mispredict_flush();
        test_full_simultaneous();
        test_errors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_branch_pred_tracker
`default_nettype wire
